// File: rtl/sdr_pkg.sv
// SDRAM burst-read shared definitions: pin command encodings, engine states, parameter checks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sdr_pkg;

    // Command encodings as {nRAS, nCAS, nWE}; nCS is held low by the engine.
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_PRE = 3'b010;

    // The pins always reflect the state of the current cycle.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACT  = 3'd1,
        S_RCD  = 3'd2,
        S_RD   = 3'd3,
        S_CAS  = 3'd4,
        S_DATA = 3'd5,
        S_PRE  = 3'd6,
        S_RP   = 3'd7
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A10 carries the auto-precharge flag, so the column must stay below it.
    function automatic bit params_ok(input int cl, input int bl, input int nrcd,
                                     input int nrp, input int col_w, input int row_w);
        return ((cl == 2) || (cl == 3)) &&
               ((bl == 1) || (bl == 2) || (bl == 4) || (bl == 8)) &&
               (nrcd >= 1) && (nrp >= 1) && (col_w <= 10) && (row_w >= 11);
    endfunction

endpackage

// File: rtl/sdr_wait_cnt.sv
// Loadable down-counter with zero flag, shared by all spacing phases of the read engine.
// Latency: load/decrement take effect on the next clock; zero_o is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module sdr_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins over a decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdr_rd_burst.sv
// SDRAM burst-read engine: ACTIVE, READ, capture BL beats, PRECHARGE/auto-precharge, done pulse.
// Latency: ack at t+1, first beat at t+2+NRCD+CL, done at t+2+NRCD+CL+BL+NRP.
// Backpressure: none; rd_req is ignored while busy and beats cannot be stalled.
module sdr_rd_burst
    import sdr_pkg::*;
#(
    parameter int DQ_W  = 16,
    parameter int BA_W  = 2,
    parameter int ROW_W = 13,
    parameter int COL_W = 9,
    parameter int CL    = 3,
    parameter int BL    = 4,
    parameter int NRCD  = 3,
    parameter int NRP   = 3,
    parameter int AP_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic              rd_ack,
    output logic [DQ_W-1:0]   rd_data,
    output logic              rd_vld,
    output logic              rd_done,
    output logic              busy,
    output logic              sdr_CKE,
    output logic              sdr_nCS,
    output logic [BA_W-1:0]   sdr_BA,
    output logic [ROW_W-1:0]  sdr_A,
    output logic              sdr_nRAS,
    output logic              sdr_nCAS,
    output logic              sdr_nWE,
    output logic [DQ_W/8-1:0] sdr_DQM,
    input  logic [DQ_W-1:0]   sdr_DQ
);

    if (!params_ok(CL, BL, NRCD, NRP, COL_W, ROW_W)) begin : g_bad_params
        $error("sdr_rd_burst: illegal CL/BL/NRCD/NRP/COL_W/ROW_W combination");
    end

    localparam int CW = $clog2(max3(NRCD, CL + BL, NRP) + 1);
    // Each phase counts down to zero; ACT already covers one cycle of tRCD.
    localparam logic [CW-1:0] LD_RCD  = (NRCD > 1) ? CW'(NRCD - 2) : '0;
    localparam logic [CW-1:0] LD_CAS  = CW'(CL - 1);
    localparam logic [CW-1:0] LD_DATA = CW'(BL - 1);
    localparam logic [CW-1:0] LD_RP   = CW'(NRP - 1);

    state_e            state_q, state_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic [ROW_W-1:0]  a_q, a_d;
    logic              ack_q, ack_d;
    logic              vld_q, vld_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [DQ_W-1:0]   data_q;
    logic [BA_W-1:0]   lat_ba_q, lat_ba_d;
    logic [COL_W-1:0]  lat_col_q, lat_col_d;
    logic [ROW_W-1:0]  rd_addr;
    logic              cnt_ld, cnt_dec, cnt_zero;
    logic [CW-1:0]     cnt_ld_val, cnt_val;

    sdr_wait_cnt #(.W(CW)) u_wait (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_ld),
        .load_val_i (cnt_ld_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    // READ address: column zero-extended, A10 selects auto-precharge.
    always_comb begin
        rd_addr                = '0;
        rd_addr[COL_W-1:0]     = lat_col_q;
        rd_addr[10]            = (AP_EN != 0);
    end

    // Next state plus next values of every registered pin/handshake output.
    always_comb begin
        state_d    = state_q;
        cmd_d      = CMD_NOP;
        ba_d       = ba_q;
        a_d        = a_q;
        ack_d      = 1'b0;
        vld_d      = 1'b0;
        done_d     = 1'b0;
        lat_ba_d   = lat_ba_q;
        lat_col_d  = lat_col_q;
        cnt_ld     = 1'b0;
        cnt_ld_val = '0;
        cnt_dec    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    state_d   = S_ACT;
                    cmd_d     = CMD_ACT;
                    ba_d      = rd_ba;
                    a_d       = rd_row;
                    ack_d     = 1'b1;
                    lat_ba_d  = rd_ba;
                    lat_col_d = rd_col;
                end
            end
            S_ACT: begin
                if (NRCD == 1) begin
                    state_d = S_RD;
                    cmd_d   = CMD_RD;
                    a_d     = rd_addr;
                end else begin
                    state_d    = S_RCD;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = LD_RCD;
                end
            end
            S_RCD: begin
                if (cnt_zero) begin
                    state_d = S_RD;
                    cmd_d   = CMD_RD;
                    a_d     = rd_addr;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_RD: begin
                state_d    = S_CAS;
                cnt_ld     = 1'b1;
                cnt_ld_val = LD_CAS;
            end
            S_CAS: begin
                // Captured data lags the pins by one register, so DATA starts at READ+CL+1.
                if (cnt_zero) begin
                    state_d    = S_DATA;
                    vld_d      = 1'b1;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = LD_DATA;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    state_d = S_PRE;
                    if (AP_EN == 0) begin
                        cmd_d = CMD_PRE;
                        ba_d  = lat_ba_q;
                        a_d   = '0;
                    end
                end else begin
                    vld_d   = 1'b1;
                    cnt_dec = 1'b1;
                end
            end
            S_PRE: begin
                state_d    = S_RP;
                cnt_ld     = 1'b1;
                cnt_ld_val = LD_RP;
                done_d     = (NRP == 1);
            end
            S_RP: begin
                // done is shown in the last RP cycle, i.e. the one whose count is zero.
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    done_d  = (cnt_val == CW'(1));
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, pins and handshakes; DQ is sampled every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_NOP;
            ba_q      <= '0;
            a_q       <= '0;
            ack_q     <= 1'b0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            lat_ba_q  <= '0;
            lat_col_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            ba_q      <= ba_d;
            a_q       <= a_d;
            ack_q     <= ack_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            data_q    <= sdr_DQ;
            lat_ba_q  <= lat_ba_d;
            lat_col_q <= lat_col_d;
        end
    end

    assign rd_ack   = ack_q;
    assign rd_vld   = vld_q;
    assign rd_done  = done_q;
    assign busy     = busy_q;
    assign rd_data  = data_q;
    assign sdr_CKE  = 1'b1;
    assign sdr_nCS  = 1'b0;
    assign sdr_BA   = ba_q;
    assign sdr_A    = a_q;
    assign {sdr_nRAS, sdr_nCAS, sdr_nWE} = cmd_q;
    assign sdr_DQM  = '0;

endmodule

// File: tb/tb_sdr_rd_burst.sv
`timescale 1ns/1ps
// Directed bench for sdr_rd_burst: three parameter sets side by side, held/pulsed requests, mid-burst reset.
// Latency: checks pin timing cycle by cycle against hand-derived schedules.
// Backpressure: n/a.
module tb_sdr_rd_burst;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] PRE = 3'b010;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [1:0]  rd_ba;
    logic [12:0] rd_row;
    logic [8:0]  rd_col;

    logic        ack  [3];
    logic [15:0] data [3];
    logic        vld  [3];
    logic        done [3];
    logic        bsy  [3];
    logic        cke  [3];
    logic        ncs  [3];
    logic [1:0]  ba   [3];
    logic [12:0] a    [3];
    logic        nras [3];
    logic        ncas [3];
    logic        nwe  [3];
    logic [1:0]  dqm  [3];
    logic [15:0] dq   [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sdr_rd_burst #(.AP_EN(0)) u_a (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_ba(rd_ba), .rd_row(rd_row), .rd_col(rd_col),
        .rd_ack(ack[0]), .rd_data(data[0]), .rd_vld(vld[0]), .rd_done(done[0]), .busy(bsy[0]),
        .sdr_CKE(cke[0]), .sdr_nCS(ncs[0]), .sdr_BA(ba[0]), .sdr_A(a[0]),
        .sdr_nRAS(nras[0]), .sdr_nCAS(ncas[0]), .sdr_nWE(nwe[0]), .sdr_DQM(dqm[0]), .sdr_DQ(dq[0])
    );

    sdr_rd_burst #(.AP_EN(1)) u_b (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_ba(rd_ba), .rd_row(rd_row), .rd_col(rd_col),
        .rd_ack(ack[1]), .rd_data(data[1]), .rd_vld(vld[1]), .rd_done(done[1]), .busy(bsy[1]),
        .sdr_CKE(cke[1]), .sdr_nCS(ncs[1]), .sdr_BA(ba[1]), .sdr_A(a[1]),
        .sdr_nRAS(nras[1]), .sdr_nCAS(ncas[1]), .sdr_nWE(nwe[1]), .sdr_DQM(dqm[1]), .sdr_DQ(dq[1])
    );

    sdr_rd_burst #(.CL(2), .BL(8), .NRCD(2)) u_c (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_ba(rd_ba), .rd_row(rd_row), .rd_col(rd_col),
        .rd_ack(ack[2]), .rd_data(data[2]), .rd_vld(vld[2]), .rd_done(done[2]), .busy(bsy[2]),
        .sdr_CKE(cke[2]), .sdr_nCS(ncs[2]), .sdr_BA(ba[2]), .sdr_A(a[2]),
        .sdr_nRAS(nras[2]), .sdr_nCAS(ncas[2]), .sdr_nWE(nwe[2]), .sdr_DQM(dqm[2]), .sdr_DQ(dq[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] cmd_of(input int i);
        return {nras[i], ncas[i], nwe[i]};
    endfunction

    // SDRAM model for defaults (CL=3, READ at 4): beats D000.. on DQ during cycles 7..10.
    function automatic logic [15:0] dq_def(input int c);
        return (c >= 7 && c <= 10) ? 16'(32'hD000 + c - 7) : 16'hEEEE;
    endfunction

    // Holds reset for two edges and returns at the start of relative cycle 0.
    task automatic do_reset();
        rst    = 1'b1;
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) dq[i] = 16'hEEEE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] e_cmd;
        rst    = 1'b1;
        rd_req = 1'b0;
        rd_ba  = 2'd2;
        rd_row = 13'h1ABC;
        rd_col = 9'h0F0;
        for (int i = 0; i < 3; i++) dq[i] = 16'hEEEE;

        // Reset state of all three instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst cmd u%0d", i),  32'(cmd_of(i)), 32'(NOP));
            check($sformatf("rst BA u%0d", i),   32'(ba[i]),     32'd0);
            check($sformatf("rst A u%0d", i),    32'(a[i]),      32'd0);
            check($sformatf("rst ack u%0d", i),  32'(ack[i]),    32'd0);
            check($sformatf("rst vld u%0d", i),  32'(vld[i]),    32'd0);
            check($sformatf("rst done u%0d", i), 32'(done[i]),   32'd0);
            check($sformatf("rst busy u%0d", i), 32'(bsy[i]),    32'd0);
            check($sformatf("rst data u%0d", i), 32'(data[i]),   32'd0);
            check($sformatf("CKE u%0d", i),      32'(cke[i]),    32'd1);
            check($sformatf("nCS u%0d", i),      32'(ncs[i]),    32'd0);
            check($sformatf("DQM u%0d", i),      32'(dqm[i]),    32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request on all three parameter sets.
        for (int c = 0; c <= 19; c++) begin
            rd_req = (c < 2);
            dq[0]  = dq_def(c);
            dq[1]  = dq_def(c);
            dq[2]  = (c >= 5 && c <= 12) ? 16'(32'hD100 + c - 5) : 16'hEEEE;
            @(negedge clk);
            // AP_EN=0 defaults
            e_cmd = (c == 1) ? ACT : (c == 4) ? RD : (c == 12) ? PRE : NOP;
            check($sformatf("s1a cmd c%0d", c),  32'(cmd_of(0)), 32'(e_cmd));
            check($sformatf("s1a ack c%0d", c),  32'(ack[0]),  32'(c == 1));
            check($sformatf("s1a busy c%0d", c), 32'(bsy[0]),  32'(c >= 1 && c <= 15));
            check($sformatf("s1a vld c%0d", c),  32'(vld[0]),  32'(c >= 8 && c <= 11));
            check($sformatf("s1a done c%0d", c), 32'(done[0]), 32'(c == 15));
            if (c >= 8 && c <= 11) check($sformatf("s1a data c%0d", c), 32'(data[0]), 32'hD000 + c - 8);
            if (c == 1) begin
                check("s1a ACT BA", 32'(ba[0]), 32'd2);
                check("s1a ACT A",  32'(a[0]),  32'h1ABC);
            end
            if (c == 4) check("s1a READ A", 32'(a[0]), 32'h00F0);
            if (c == 12) begin
                check("s1a PRE A10", 32'(a[0][10]), 32'd0);
                check("s1a PRE BA",  32'(ba[0]),    32'd2);
            end
            // AP_EN=1
            e_cmd = (c == 1) ? ACT : (c == 4) ? RD : NOP;
            check($sformatf("s1b cmd c%0d", c),  32'(cmd_of(1)), 32'(e_cmd));
            check($sformatf("s1b vld c%0d", c),  32'(vld[1]),  32'(c >= 8 && c <= 11));
            check($sformatf("s1b done c%0d", c), 32'(done[1]), 32'(c == 15));
            if (c >= 8 && c <= 11) check($sformatf("s1b data c%0d", c), 32'(data[1]), 32'hD000 + c - 8);
            if (c == 4) check("s1b READ A", 32'(a[1]), 32'h04F0);
            // CL=2, BL=8, NRCD=2
            e_cmd = (c == 1) ? ACT : (c == 3) ? RD : (c == 14) ? PRE : NOP;
            check($sformatf("s1c cmd c%0d", c),  32'(cmd_of(2)), 32'(e_cmd));
            check($sformatf("s1c busy c%0d", c), 32'(bsy[2]),  32'(c >= 1 && c <= 17));
            check($sformatf("s1c vld c%0d", c),  32'(vld[2]),  32'(c >= 6 && c <= 13));
            check($sformatf("s1c done c%0d", c), 32'(done[2]), 32'(c == 17));
            if (c >= 6 && c <= 13) check($sformatf("s1c data c%0d", c), 32'(data[2]), 32'hD100 + c - 6);
            if (c == 3) check("s1c READ A", 32'(a[2]), 32'h00F0);
            @(posedge clk);
            #1;
        end

        // Request held high: second accept only after the first completes.
        do_reset();
        for (int c = 0; c <= 19; c++) begin
            rd_req = (c <= 17);
            dq[0]  = dq_def(c);
            @(negedge clk);
            check($sformatf("s2 ack c%0d", c),  32'(ack[0]),  32'(c == 1 || c == 17));
            check($sformatf("s2 busy c%0d", c), 32'(bsy[0]),  32'((c >= 1 && c <= 15) || c >= 17));
            check($sformatf("s2 vld c%0d", c),  32'(vld[0]),  32'(c >= 8 && c <= 11));
            check($sformatf("s2 done c%0d", c), 32'(done[0]), 32'(c == 15));
            @(posedge clk);
            #1;
        end

        // Reset during the burst, then a fresh request.
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            rst    = (c == 9);
            rd_req = (c < 2) || (c == 12) || (c == 13);
            dq[0]  = dq_def(c);
            @(negedge clk);
            e_cmd = (c == 1 || c == 13) ? ACT : (c == 4) ? RD : NOP;
            check($sformatf("s3 cmd c%0d", c),  32'(cmd_of(0)), 32'(e_cmd));
            check($sformatf("s3 ack c%0d", c),  32'(ack[0]),  32'(c == 1 || c == 13));
            check($sformatf("s3 busy c%0d", c), 32'(bsy[0]),  32'((c >= 1 && c <= 9) || c >= 13));
            check($sformatf("s3 vld c%0d", c),  32'(vld[0]),  32'(c == 8 || c == 9));
            check($sformatf("s3 done c%0d", c), 32'(done[0]), 32'd0);
            if (c == 8 || c == 9) check($sformatf("s3 data c%0d", c), 32'(data[0]), 32'hD000 + c - 8);
            if (c == 10) check("s3 data after rst", 32'(data[0]), 32'd0);
            if (c == 13) check("s3 ACT A", 32'(a[0]), 32'h1ABC);
            @(posedge clk);
            #1;
        end

        // Request pulse while busy is dropped.
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            rd_req = (c < 2) || (c == 6);
            dq[0]  = dq_def(c);
            @(negedge clk);
            e_cmd = (c == 1) ? ACT : (c == 4) ? RD : (c == 12) ? PRE : NOP;
            check($sformatf("s4 cmd c%0d", c),  32'(cmd_of(0)), 32'(e_cmd));
            check($sformatf("s4 ack c%0d", c),  32'(ack[0]),  32'(c == 1));
            check($sformatf("s4 busy c%0d", c), 32'(bsy[0]),  32'(c >= 1 && c <= 15));
            check($sformatf("s4 vld c%0d", c),  32'(vld[0]),  32'(c >= 8 && c <= 11));
            check($sformatf("s4 done c%0d", c), 32'(done[0]), 32'(c == 15));
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
